// File: rtl/fir_seq_mac_pkg.sv
// Shared types and helpers for the sequential-MAC FIR.
//   state_t   : control states of the filter (IDLE, MAC, OUT)
//   acc_width : accumulator width that cannot overflow over N_TAPS products
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int n_taps);
        return data_w + coef_w + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/fir_seq_mac_if.sv
// Sample/result/coefficient bus of the sequential-MAC FIR.
//   in_valid/in_ready/in_data    : sample stream into the filter
//   out_valid/out_ready/out_data : filtered result stream out of the filter
//   coef_wr/coef_addr/coef_data  : coefficient write port (honoured only while idle)
//   busy                         : filter is working on a sample or holding a result
// master = sample source / result consumer / coefficient writer, slave = the filter.
interface fir_seq_mac_if #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32,
    parameter int N_TAPS = 15
);
    localparam int AW = $clog2(N_TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     coef_wr;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready, coef_wr, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_wr, coef_addr, coef_data,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/fir_seq_mac_round_sat.sv
// Combinational output scaling: round half up, arithmetic right shift by SHIFT,
// then clamp to the signed OUT_W range.
//   acc : signed accumulator, ACC_W bits
//   y   : signed scaled and saturated result, OUT_W bits
module fir_round_sat #(
    parameter int ACC_W = 32,
    parameter int SHIFT = 0,
    parameter int OUT_W = 32
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y
);
    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = ACC_W + 1;

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shifted;

    assign ext = EXT_W'(acc);

    generate
        if (SHIFT == 0) begin : g_no_round
            assign shifted = ext;
        end else begin : g_round
            localparam logic signed [EXT_W-1:0] HALF = EXT_W'(64'sd1 <<< (SHIFT - 1));
            assign shifted = (ext + HALF) >>> SHIFT;
        end

        if (OUT_W >= EXT_W) begin : g_wide
            assign y = OUT_W'(shifted);
        end else begin : g_clamp
            localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
            localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

            always_comb begin
                if (shifted > MAX_V) begin
                    y = MAX_V[OUT_W-1:0];
                end else if (shifted < MIN_V) begin
                    y = MIN_V[OUT_W-1:0];
                end else begin
                    y = shifted[OUT_W-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR filter: one multiply-accumulate per cycle over a
// circular delay line, runtime-writable coefficients, rounded and saturated output.
//   clk    : clock, rising edge
//   nreset : asynchronous active-low reset
//   bus    : fir_seq_mac_if.slave (sample in, result out, coefficient write, busy)
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int N_TAPS = 15,
    parameter int DATA_W = 12,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic           clk,
    input  logic           nreset,
    fir_seq_mac_if.slave   bus
);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, N_TAPS);
    localparam int AW     = $clog2(N_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST_K = AW'(N_TAPS - 1);
    localparam logic [AW-1:0] ONE    = AW'(1);

    state_t state, state_nx;

    logic signed [DATA_W-1:0] dl   [N_TAPS];
    logic signed [COEF_W-1:0] coef [N_TAPS];
    logic [AW-1:0]            wp;
    logic [AW-1:0]            k;
    logic [AW-1:0]            rd;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0]  sat_out;
    logic signed [OUT_W-1:0]  out_data_r;
    logic                     accept;
    logic                     mac_last;
    logic                     coef_ok;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        mac_last      = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated with nreset so the source sees not-ready while reset is held.
                bus.in_ready = nreset;
                if (bus.in_valid && nreset) begin
                    accept   = 1'b1;
                    state_nx = MAC;
                end
            end
            MAC: begin
                mac_last = (k == LAST_K);
                if (mac_last) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.out_data = out_data_r;

    assign coef_ok = (state == IDLE) && bus.coef_wr && (int'(bus.coef_addr) < N_TAPS);

    // Tap k reads the sample k steps older than the newest one at wp.
    // Modulo-2^AW wrap of wp-k is undone by adding N_TAPS when k > wp.
    assign rd      = (wp >= k) ? (wp - k) : (wp - k + AW'(N_TAPS));
    assign prod    = dl[rd] * coef[k];
    assign acc_sum = acc + ACC_W'(prod);

    // Scaling is applied to the sum including the final product, so the
    // result is registered on the same edge that enters OUT.
    fir_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc (acc_sum),
        .y   (sat_out)
    );

    // NOTE: the delay line and coefficients are flop arrays, not RAM, and are
    // cleared by reset because the filter must restart from a known impulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                dl[i]   <= '0;
                coef[i] <= (i == 0) ? COEF_W'(1) : '0;
            end
            wp         <= '0;
            k          <= '0;
            acc        <= '0;
            out_data_r <= '0;
        end else begin
            if (coef_ok) begin
                coef[bus.coef_addr] <= bus.coef_data;
            end
            if (accept) begin
                dl[wp] <= bus.in_data;
                acc    <= '0;
                k      <= '0;
            end
            if (state == MAC) begin
                acc <= acc_sum;
                if (mac_last) begin
                    k          <= '0;
                    wp         <= (wp == LAST_K) ? '0 : wp + ONE;
                    out_data_r <= sat_out;
                end else begin
                    k <= k + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Self-checking bench for fir_seq_mac: three instances (defaults, OUT_W=16,
// SHIFT=2) driven through their interfaces; expected results come from a
// dot-product model over the sample history and are checked by a monitor.
module tb_fir_seq_mac;

    localparam int N = 15;
    localparam int OUTW [3] = '{32, 16, 32};
    localparam int SH   [3] = '{0, 0, 2};
    localparam int TAPS [15] = '{1, -2, 2, 18, -8, -62, 6, 90, 6, -62, -8, 18, 2, -2, 1};

    logic clk;
    logic nreset;

    logic        in_valid  [3];
    logic [11:0] in_data   [3];
    logic        out_ready [3];
    logic        coef_wr   [3];
    logic [3:0]  coef_addr [3];
    logic [15:0] coef_data [3];
    logic        in_ready_o  [3];
    logic        out_valid_o [3];
    logic        busy_o      [3];
    longint      out_o       [3];

    int checks   = 0;
    int failures = 0;

    longint exp_q    [3][$];
    longint hist     [3][$];
    longint mdl_coef [3][15];
    time    acc_time [3];

    fir_seq_mac_if #(.DATA_W(12), .COEF_W(16), .OUT_W(32), .N_TAPS(15)) if0 ();
    fir_seq_mac_if #(.DATA_W(12), .COEF_W(16), .OUT_W(16), .N_TAPS(15)) if1 ();
    fir_seq_mac_if #(.DATA_W(12), .COEF_W(16), .OUT_W(32), .N_TAPS(15)) if2 ();

    fir_seq_mac #(.N_TAPS(15), .DATA_W(12), .COEF_W(16), .OUT_W(32), .SHIFT(0))
        dut0 (.clk(clk), .nreset(nreset), .bus(if0.slave));
    fir_seq_mac #(.N_TAPS(15), .DATA_W(12), .COEF_W(16), .OUT_W(16), .SHIFT(0))
        dut1 (.clk(clk), .nreset(nreset), .bus(if1.slave));
    fir_seq_mac #(.N_TAPS(15), .DATA_W(12), .COEF_W(16), .OUT_W(32), .SHIFT(2))
        dut2 (.clk(clk), .nreset(nreset), .bus(if2.slave));

    assign if0.in_valid = in_valid[0];   assign if1.in_valid = in_valid[1];   assign if2.in_valid = in_valid[2];
    assign if0.in_data  = in_data[0];    assign if1.in_data  = in_data[1];    assign if2.in_data  = in_data[2];
    assign if0.out_ready = out_ready[0]; assign if1.out_ready = out_ready[1]; assign if2.out_ready = out_ready[2];
    assign if0.coef_wr   = coef_wr[0];   assign if1.coef_wr   = coef_wr[1];   assign if2.coef_wr   = coef_wr[2];
    assign if0.coef_addr = coef_addr[0]; assign if1.coef_addr = coef_addr[1]; assign if2.coef_addr = coef_addr[2];
    assign if0.coef_data = coef_data[0]; assign if1.coef_data = coef_data[1]; assign if2.coef_data = coef_data[2];

    assign in_ready_o[0]  = if0.in_ready;  assign in_ready_o[1]  = if1.in_ready;  assign in_ready_o[2]  = if2.in_ready;
    assign out_valid_o[0] = if0.out_valid; assign out_valid_o[1] = if1.out_valid; assign out_valid_o[2] = if2.out_valid;
    assign busy_o[0]      = if0.busy;      assign busy_o[1]      = if1.busy;      assign busy_o[2]      = if2.busy;
    assign out_o[0] = longint'(if0.out_data);
    assign out_o[1] = longint'(if1.out_data);
    assign out_o[2] = longint'(if2.out_data);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at t=%0t", name, $time);
    endtask

    // Reference: dot product of coefficients with the sample history
    // (newest first), then round half up, shift and clamp.
    function automatic longint model_out(input int i);
        longint acc = 0;
        longint hi;
        longint lo;
        for (int t = 0; t < hist[i].size(); t++) begin
            acc += hist[i][t] * mdl_coef[i][t];
        end
        if (SH[i] > 0) begin
            acc = (acc + (longint'(1) <<< (SH[i] - 1))) >>> SH[i];
        end
        hi = (longint'(1) <<< (OUTW[i] - 1)) - 1;
        lo = -hi - 1;
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
        return acc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i].delete();
            for (int t = 0; t < N; t++) mdl_coef[i][t] = (t == 0) ? 1 : 0;
        end
    endtask

    task automatic model_accept(input int i, input int x, input bit track);
        hist[i].push_front(longint'(x));
        if (hist[i].size() > N) void'(hist[i].pop_back());
        if (track) exp_q[i].push_back(model_out(i));
    endtask

    // Monitor: every result handshake pops one expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (nreset && out_valid_o[i] && out_ready[i]) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output inst=%0d actual=%0d required=none", i, out_o[i]);
                end else begin
                    check($sformatf("out_data inst%0d", i), out_o[i], exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic send(input int i, input int x, input bit track);
        int n = 0;
        @(negedge clk);
        in_valid[i] = 1'b1;
        in_data[i]  = 12'(x);
        while (!in_ready_o[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout_fail("accept");
        @(posedge clk);
        acc_time[i] = $time;
        model_accept(i, x, track);
        #1 in_valid[i] = 1'b0;
    endtask

    task automatic send_lat(input int i, input int x);
        int lat = 0;
        send(i, x, 1'b1);
        while (!out_valid_o[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, N + 1);
    endtask

    task automatic write_coef(input int i, input int a, input int v);
        int n = 0;
        @(negedge clk);
        while (busy_o[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout_fail("coef_wait");
        coef_wr[i]   = 1'b1;
        coef_addr[i] = 4'(a);
        coef_data[i] = 16'(v);
        @(posedge clk);
        #1 coef_wr[i] = 1'b0;
        if (a < N) mdl_coef[i][a] = longint'(v);
    endtask

    task automatic drain(input int i);
        int n = 0;
        while (exp_q[i].size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeout_fail($sformatf("drain inst%0d", i));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        nreset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset in_ready", longint'(in_ready_o[i]), 0);
            check("reset out_valid", longint'(out_valid_o[i]), 0);
            check("reset busy", longint'(busy_o[i]), 0);
            check("reset out_data", out_o[i], 0);
        end
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("idle in_ready", longint'(in_ready_o[i]), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        time t_a;
        time t_hs;
        longint held;
        int n;

        nreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
            coef_wr[i] = 1'b0; coef_addr[i] = '0; coef_data[i] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        apply_reset();

        // Pass-through after reset, with latency measured per sample.
        send_lat(0, 5);
        send_lat(0, -7);
        send_lat(0, 2047);
        drain(0);

        // Back-to-back samples: accept edges one minimum period apart.
        send(0, 3, 1'b1);
        t_a = acc_time[0];
        send(0, 4, 1'b1);
        check("sample_period", longint'((acc_time[0] - t_a) / 10), N + 2);
        drain(0);

        // Impulse response with a clean delay line, then wrap with zeros.
        apply_reset();
        for (int t = 0; t < N; t++) write_coef(0, t, TAPS[t]);
        send(0, 1, 1'b1);
        for (int t = 0; t < 29; t++) send(0, 0, 1'b1);
        drain(0);

        // Backpressure: result held, new sample refused until the handshake.
        send(0, 100, 1'b1);
        out_ready[0] = 1'b0;
        n = 0;
        while (!out_valid_o[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeout_fail("wait_out");
        held = (exp_q[0].size() != 0) ? exp_q[0][0] : 0;
        in_valid[0] = 1'b1;
        in_data[0]  = 12'(55);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("stall out_valid", longint'(out_valid_o[0]), 1);
            check("stall out_data", out_o[0], held);
            check("stall in_ready", longint'(in_ready_o[0]), 0);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        @(posedge clk);
        t_hs = $time;
        @(negedge clk);
        check("post_hs out_valid", longint'(out_valid_o[0]), 0);
        check("post_hs out_data", out_o[0], held);
        check("post_hs in_ready", longint'(in_ready_o[0]), 1);
        @(posedge clk);
        check("accept_after_hs", longint'(($time - t_hs) / 10), 1);
        model_accept(0, 55, 1'b1);
        #1 in_valid[0] = 1'b0;
        check("busy_after_accept", longint'(busy_o[0]), 1);
        drain(0);

        // Random coefficients and samples with random consumer stalls.
        for (int t = 0; t < N; t++) write_coef(0, t, int'($urandom_range(0, 65535)) - 32768);
        for (int s = 0; s < 20; s++) begin
            send(0, int'($urandom_range(0, 4095)) - 2048, 1'b1);
            out_ready[0] = 1'b0;
            repeat ($urandom_range(0, 24)) @(posedge clk);
            #1 out_ready[0] = 1'b1;
        end
        drain(0);

        // Coefficient writes while busy or out of range are ignored.
        for (int t = 0; t < N; t++) write_coef(0, t, (t == 0) ? 1 : 0);
        send(0, 1, 1'b1);
        repeat (3) @(negedge clk);
        check("busy_in_mac", longint'(busy_o[0]), 1);
        coef_wr[0] = 1'b1; coef_addr[0] = 4'd0; coef_data[0] = 16'd3;
        @(posedge clk);
        #1 coef_wr[0] = 1'b0;
        drain(0);
        write_coef(0, 15, 99);
        send(0, 1, 1'b1);
        send(0, -300, 1'b1);
        drain(0);

        // Saturation at OUT_W=16.
        for (int t = 0; t < N; t++) write_coef(1, t, (t == 7) ? 90 : 0);
        for (int s = 0; s < N; s++) send(1, 2047, 1'b1);
        for (int s = 0; s < N; s++) send(1, -2048, 1'b1);
        drain(1);

        // Round half up with SHIFT=2, then random coefficients/samples.
        send(2, 6, 1'b1);
        send(2, -6, 1'b1);
        send(2, 5, 1'b1);
        drain(2);
        for (int t = 0; t < N; t++) write_coef(2, t, int'($urandom_range(0, 65535)) - 32768);
        for (int s = 0; s < 10; s++) send(2, int'($urandom_range(0, 4095)) - 2048, 1'b1);
        drain(2);

        // Reset mid-MAC discards the partial result and restores coefficients.
        write_coef(0, 0, 3);
        send(0, 4, 1'b0);
        repeat (5) @(negedge clk);
        apply_reset();
        repeat (30) @(negedge clk);
        check("abort out_valid", longint'(out_valid_o[0]), 0);
        check("abort busy", longint'(busy_o[0]), 0);
        send(0, 9, 1'b1);
        drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
